// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the serial command initiator: opcodes, response
// lengths, FSM states and the response-length clamp.
package serial_cmd_pkg;

    localparam logic [7:0] OP_VERSION  = 8'd0;
    localparam logic [7:0] OP_CALIB    = 8'd1;
    localparam logic [7:0] OP_HISTOSEL = 8'd2;
    localparam logic [7:0] OP_OUTEN    = 8'd3;
    localparam logic [7:0] OP_CLKSW    = 8'd4;
    localparam logic [7:0] OP_PHASE    = 8'd5;
    localparam logic [7:0] OP_SEED     = 8'd6;
    localparam logic [7:0] OP_ACTCLK   = 8'd8;
    localparam logic [7:0] OP_PHASEDIR = 8'd9;
    localparam logic [7:0] OP_HISTO    = 8'd10;
    localparam logic [7:0] OP_DELAY    = 8'd11;
    localparam logic [7:0] OP_PHASE_C1 = 8'd12;

    localparam logic [5:0] RESP_LEN_VERSION = 6'd1;
    localparam logic [5:0] RESP_LEN_ACTCLK  = 6'd1;
    localparam logic [5:0] RESP_LEN_HISTO   = 6'd32;
    localparam logic [5:0] RESP_LEN_DELAY   = 6'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_OP,
        S_TX_OP_GAP,
        S_TX_ARG,
        S_TX_ARG_GAP,
        S_RECV,
        S_FINISH
    } state_t;

    function automatic logic [5:0] clamp_len(input logic [5:0] len, input int max_resp);
        return (int'(len) > max_resp) ? 6'(max_resp) : len;
    endfunction

endpackage

// File: rtl/serial_rx_timeout.sv
// Inter-byte watchdog: reloads to TIMEOUT_CYCLES-1, counts down while enabled,
// and flags terminal count at zero.
module serial_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/serial_cmd_master.sv
// Initiator for the board serial command protocol: sends opcode (+ optional
// argument) over UART and streams back a fixed-length response.
// Optional SERIAL_CMD_HISTO_UNPACK_EN adds little-endian unpacking into 8x32-bit words.
module serial_cmd_master
    import serial_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_RESP       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [7:0]   cmd_op,
    input  logic         cmd_has_arg,
    input  logic [7:0]   cmd_arg,
    input  logic [5:0]   cmd_resp_len,
    input  logic         txBusy,
    output logic         txStart,
    output logic [7:0]   txData,
    input  logic         rxReady,
    input  logic [7:0]   rxData,
    output logic         resp_valid,
    output logic [7:0]   resp_byte,
    output logic [5:0]   resp_index,
    output logic         done,
    output logic         timeout_err,
    output logic [7:0]   stray_count
`ifdef SERIAL_CMD_HISTO_UNPACK_EN
    ,
    output logic [255:0] histo_words,
    output logic         histo_valid
`endif
);

    state_t     state_q, state_d;
    logic [7:0] arg_q;
    logic       has_arg_q;
    logic [5:0] len_q;
    logic [5:0] count_q;
    logic       accept, rx_take, to_hit, to_load, to_en, to_tc;

    assign accept = (state_q == S_IDLE) && cmd_valid;

    serial_rx_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == S_IDLE),
        .load  (to_load),
        .en    (to_en),
        .tc    (to_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d   = state_q;
        cmd_ready = 1'b0;
        txStart   = 1'b0;
        done      = 1'b0;
        rx_take   = 1'b0;
        to_hit    = 1'b0;
        to_load   = 1'b0;
        to_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_TX_OP;
            end
            S_TX_OP: begin
                if (!txBusy) begin
                    txStart = 1'b1;
                    state_d = S_TX_OP_GAP;
                end
            end
            S_TX_OP_GAP: begin
                if (has_arg_q) begin
                    state_d = S_TX_ARG;
                end else if (len_q != 6'd0) begin
                    state_d = S_RECV;
                    to_load = 1'b1;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_TX_ARG: begin
                if (!txBusy) begin
                    txStart = 1'b1;
                    state_d = S_TX_ARG_GAP;
                end
            end
            S_TX_ARG_GAP: begin
                if (len_q != 6'd0) begin
                    state_d = S_RECV;
                    to_load = 1'b1;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_RECV: begin
                // A byte arriving on the terminal-count cycle wins over the timeout.
                if (rxReady) begin
                    rx_take = 1'b1;
                    to_load = 1'b1;
                    if (count_q + 6'd1 == len_q) state_d = S_FINISH;
                end else if (to_tc) begin
                    to_hit  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_en = 1'b1;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txData      <= 8'h00;
            arg_q       <= 8'h00;
            has_arg_q   <= 1'b0;
            len_q       <= 6'd0;
            count_q     <= 6'd0;
            resp_valid  <= 1'b0;
            resp_byte   <= 8'h00;
            resp_index  <= 6'd0;
            timeout_err <= 1'b0;
            stray_count <= 8'h00;
        end else begin
            resp_valid  <= rx_take;
            timeout_err <= to_hit;
            if (accept) begin
                txData    <= cmd_op;
                arg_q     <= cmd_arg;
                has_arg_q <= cmd_has_arg;
                len_q     <= clamp_len(cmd_resp_len, MAX_RESP);
                count_q   <= 6'd0;
            end
            if (state_q == S_TX_OP_GAP && has_arg_q) txData <= arg_q;
            if (rx_take) begin
                resp_byte  <= rxData;
                resp_index <= count_q;
                count_q    <= count_q + 6'd1;
            end
            if (rxReady && state_q != S_RECV && stray_count != 8'hFF)
                stray_count <= stray_count + 8'h01;
        end
    end

`ifdef SERIAL_CMD_HISTO_UNPACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       histo_words <= '0;
        else if (accept)  histo_words <= '0;
        else if (rx_take) histo_words[{count_q[4:0], 3'b000} +: 8] <= rxData;
    end

    assign histo_valid = done && (len_q == 6'd32);
`endif

endmodule

// File: tb/tb_serial_cmd_master.sv
// Self-checking bench for serial_cmd_master: UART transmitter model, scripted
// and randomized transactions checked against a transaction-level model.
module tb_serial_cmd_master;
    import serial_cmd_pkg::*;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_has_arg = 1'b0;
    logic [7:0] cmd_op = 8'h00, cmd_arg = 8'h00;
    logic [5:0] cmd_resp_len = 6'd0;
    logic       txBusy, txStart;
    logic [7:0] txData;
    logic       rxReady = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       resp_valid, done, timeout_err;
    logic [7:0] resp_byte, stray_count;
    logic [5:0] resp_index;
`ifdef SERIAL_CMD_HISTO_UNPACK_EN
    logic [255:0] histo_words, hw_snap;
    logic         histo_valid;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    serial_cmd_master #(.TIMEOUT_CYCLES(TO), .MAX_RESP(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_has_arg  (cmd_has_arg),
        .cmd_arg      (cmd_arg),
        .cmd_resp_len (cmd_resp_len),
        .txBusy       (txBusy),
        .txStart      (txStart),
        .txData       (txData),
        .rxReady      (rxReady),
        .rxData       (rxData),
        .resp_valid   (resp_valid),
        .resp_byte    (resp_byte),
        .resp_index   (resp_index),
        .done         (done),
        .timeout_err  (timeout_err),
        .stray_count  (stray_count)
`ifdef SERIAL_CMD_HISTO_UNPACK_EN
        ,
        .histo_words  (histo_words),
        .histo_valid  (histo_valid)
`endif
    );

    // UART transmitter model: busy for busy_len cycles after each start strobe.
    int   busy_len = 0, busy_cnt = 0;
    logic force_busy = 1'b0;
    assign txBusy = force_busy | (busy_cnt != 0);

    always @(posedge clk) begin
        if (txStart)            busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Event log, sampled on the rising edge so tasks can read it on falling edges.
    logic [7:0] tx_log[$], resp_b[$];
    int         resp_i[$], tx_cyc[$];
    int         cyc = 0, done_cnt = 0, to_cnt = 0, viol = 0, hv_cnt = 0;
    int         last_resp_cyc = 0, to_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (txStart) begin
            tx_log.push_back(txData);
            tx_cyc.push_back(cyc);
            if (txBusy) viol++;
        end
        if (resp_valid) begin
            resp_b.push_back(resp_byte);
            resp_i.push_back(int'(resp_index));
            last_resp_cyc = cyc;
        end
        if (done) done_cnt++;
        if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
`ifdef SERIAL_CMD_HISTO_UNPACK_EN
        if (histo_valid) begin
            if (done) hv_cnt++;
            hw_snap = histo_words;
        end
`endif
    end

    task automatic clear_logs();
        tx_log.delete(); resp_b.delete(); resp_i.delete(); tx_cyc.delete();
        done_cnt = 0; to_cnt = 0; viol = 0; hv_cnt = 0;
    endtask

    task automatic issue_cmd(input logic [7:0] op, input logic has_arg,
                             input logic [7:0] arg, input logic [5:0] len);
        int g = 0;
        while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_op = op; cmd_has_arg = has_arg; cmd_arg = arg; cmd_resp_len = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for n start strobes, then one more cycle so the DUT has left the gap state.
    task automatic wait_tx(input int n);
        int g = 0;
        while (tx_log.size() < n && g < 500) begin @(negedge clk); g++; end
        checks++;
        if (tx_log.size() != n) begin
            errors++;
            $display("FAIL tx_count: got %0d strobes required %0d", tx_log.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rxData = b; rxReady = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_end();
        int g = 0;
        while (done_cnt == 0 && to_cnt == 0 && g < 400) begin @(negedge clk); g++; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, txStart, resp_valid, done, timeout_err, txData, resp_byte, resp_index, stray_count}
            !== {1'b1, 4'b0000, 8'h00, 8'h00, 6'd0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b txs=%b rv=%b dn=%b to=%b txd=%h rb=%h ri=%0d sc=%0d required 1 0 0 0 0 00 00 0 0",
                     cmd_ready, txStart, resp_valid, done, timeout_err, txData, resp_byte, resp_index, stray_count);
        end
    endtask

    task automatic test_version();
        clear_logs(); busy_len = 3;
        issue_cmd(OP_VERSION, 1'b0, 8'h00, RESP_LEN_VERSION);
        wait_tx(1);
        send_byte(8'h04, 0);
        wait_end();
        checks++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h00) begin
            errors++;
            $display("FAIL version_tx: size=%0d first=%h required 1 00", tx_log.size(), tx_log.size() ? tx_log[0] : 8'hxx);
        end
        checks++;
        if (resp_b.size() != 1 || resp_b[0] !== 8'h04 || resp_i[0] != 0) begin
            errors++;
            $display("FAIL version_resp: count=%0d required 1 byte 04 index 0", resp_b.size());
        end
        checks++;
        if (done_cnt != 1 || to_cnt != 0) begin
            errors++;
            $display("FAIL version_done: done=%0d timeout=%0d required 1 0", done_cnt, to_cnt);
        end
    endtask

    task automatic test_arg_busy();
        clear_logs(); busy_len = 5;
        issue_cmd(OP_CALIB, 1'b1, 8'h0A, 6'd0);
        wait_tx(2);
        wait_end();
        checks++;
        if (tx_log.size() != 2 || tx_log[0] !== OP_CALIB || tx_log[1] !== 8'h0A) begin
            errors++;
            $display("FAIL arg_tx_bytes: size=%0d required 2 bytes 01 0a", tx_log.size());
        end
        checks++;
        if (tx_cyc.size() != 2 || tx_cyc[1] - tx_cyc[0] != 6) begin
            errors++;
            $display("FAIL arg_tx_spacing: got %0d cycles required 6", tx_cyc.size() == 2 ? tx_cyc[1] - tx_cyc[0] : -1);
        end
        checks++;
        if (resp_b.size() != 0 || done_cnt != 1 || viol != 0) begin
            errors++;
            $display("FAIL arg_done: resp=%0d done=%0d busy_violations=%0d required 0 1 0", resp_b.size(), done_cnt, viol);
        end
    endtask

    task automatic test_histo();
        clear_logs(); busy_len = 2;
        issue_cmd(OP_HISTO, 1'b0, 8'h00, RESP_LEN_HISTO);
        wait_tx(1);
        for (int i = 0; i < 32; i++) send_byte(8'(i), $urandom_range(0, 3));
        wait_end();
        checks++;
        if (resp_b.size() != 32) begin
            errors++;
            $display("FAIL histo_count: got %0d required 32", resp_b.size());
        end
        for (int i = 0; i < resp_b.size(); i++) begin
            checks++;
            if (resp_b[i] !== 8'(i) || resp_i[i] != i) begin
                errors++;
                $display("FAIL histo_byte[%0d]: got %h idx %0d required %h idx %0d", i, resp_b[i], resp_i[i], 8'(i), i);
            end
        end
        checks++;
        if (done_cnt != 1 || to_cnt != 0) begin
            errors++;
            $display("FAIL histo_done: done=%0d timeout=%0d required 1 0", done_cnt, to_cnt);
        end
`ifdef SERIAL_CMD_HISTO_UNPACK_EN
        checks++;
        if (hv_cnt != 1 || hw_snap[31:0] !== 32'h03020100 || hw_snap[255:224] !== 32'h1F1E1D1C) begin
            errors++;
            $display("FAIL histo_unpack: pulses=%0d w0=%h w7=%h required 1 03020100 1f1e1d1c", hv_cnt, hw_snap[31:0], hw_snap[255:224]);
        end
`endif
    endtask

    task automatic test_timeout();
        clear_logs(); busy_len = 1;
        issue_cmd(OP_DELAY, 1'b0, 8'h00, RESP_LEN_DELAY);
        wait_tx(1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2);
        wait_end();
        checks++;
        if (resp_b.size() != 3 || to_cnt != 1 || done_cnt != 0) begin
            errors++;
            $display("FAIL timeout_outcome: resp=%0d timeout=%0d done=%0d required 3 1 0", resp_b.size(), to_cnt, done_cnt);
        end
        checks++;
        if (to_cyc - last_resp_cyc != TO) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles required %0d", to_cyc - last_resp_cyc, TO);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_stray();
        logic [7:0] s0;
        clear_logs(); busy_len = 2;
        s0 = stray_count;
        send_byte(8'hA1, 1);
        send_byte(8'hA2, 1);
        force_busy = 1'b1;
        issue_cmd(OP_ACTCLK, 1'b0, 8'h00, RESP_LEN_ACTCLK);
        send_byte(8'h55, 1);
        force_busy = 1'b0;
        wait_tx(1);
        send_byte(8'h08, 0);
        wait_end();
        checks++;
        if (stray_count !== s0 + 8'd3) begin
            errors++;
            $display("FAIL stray_count: got %0d required %0d", stray_count, s0 + 8'd3);
        end
        checks++;
        if (resp_b.size() != 1 || resp_b[0] !== 8'h08 || done_cnt != 1) begin
            errors++;
            $display("FAIL stray_resp: count=%0d done=%0d required 1 byte 08 done 1", resp_b.size(), done_cnt);
        end
        for (int i = 0; i < 260; i++) send_byte(8'($urandom), 0);
        checks++;
        if (stray_count !== 8'hFF) begin
            errors++;
            $display("FAIL stray_saturate: got %0d required 255", stray_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] ops[12] = '{OP_VERSION, OP_CALIB, OP_HISTOSEL, OP_OUTEN, OP_CLKSW, OP_PHASE,
                                OP_SEED, OP_ACTCLK, OP_PHASEDIR, OP_HISTO, OP_DELAY, OP_PHASE_C1};
        for (int t = 0; t < 20; t++) begin
            logic [7:0] op, arg, sent[$];
            logic       has_arg;
            logic [5:0] len;
            int         exp_len, nsend;
            bit         complete;
            clear_logs();
            op = ops[$urandom_range(0, 11)];
            has_arg = 1'($urandom);
            arg = 8'($urandom);
            len = 6'($urandom_range(0, 40));
            exp_len = (len > 32) ? 32 : int'(len);
            nsend = exp_len;
            if (exp_len > 0 && $urandom_range(0, 4) == 0) nsend = $urandom_range(0, exp_len - 1);
            complete = (nsend == exp_len);
            busy_len = $urandom_range(0, 4);
            issue_cmd(op, has_arg, arg, len);
            wait_tx(has_arg ? 2 : 1);
            for (int i = 0; i < nsend; i++) begin
                sent.push_back(8'($urandom));
                send_byte(sent[i], $urandom_range(0, 5));
            end
            wait_end();
            checks++;
            if (tx_log.size() != (has_arg ? 2 : 1) || tx_log[0] !== op || (has_arg && tx_log[1] !== arg)) begin
                errors++;
                $display("FAIL rand%0d_tx: size=%0d op=%h arg=%h has_arg=%b", t, tx_log.size(), op, arg, has_arg);
            end
            checks++;
            if (resp_b.size() != nsend) begin
                errors++;
                $display("FAIL rand%0d_resp_count: got %0d required %0d", t, resp_b.size(), nsend);
            end
            for (int i = 0; i < resp_b.size() && i < nsend; i++) begin
                checks++;
                if (resp_b[i] !== sent[i] || resp_i[i] != i) begin
                    errors++;
                    $display("FAIL rand%0d_byte[%0d]: got %h idx %0d required %h idx %0d", t, i, resp_b[i], resp_i[i], sent[i], i);
                end
            end
            checks++;
            if (done_cnt != int'(complete) || to_cnt != int'(!complete) || viol != 0) begin
                errors++;
                $display("FAIL rand%0d_end: done=%0d timeout=%0d viol=%0d required %0d %0d 0", t, done_cnt, to_cnt, viol, complete, !complete);
            end
        end
    endtask

    task automatic test_reset_mid_recv();
        clear_logs(); busy_len = 1;
        issue_cmd(OP_DELAY, 1'b0, 8'h00, RESP_LEN_DELAY);
        wait_tx(1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, txStart, resp_valid, done, timeout_err, txData, resp_byte, resp_index, stray_count}
            !== {1'b1, 4'b0000, 8'h00, 8'h00, 6'd0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: rdy=%b txs=%b rv=%b dn=%b to=%b txd=%h rb=%h ri=%0d sc=%0d required 1 0 0 0 0 00 00 0 0",
                     cmd_ready, txStart, resp_valid, done, timeout_err, txData, resp_byte, resp_index, stray_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (TO + 20) @(negedge clk);
        checks++;
        if (done_cnt != 0 || to_cnt != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: done=%0d timeout=%0d required 0 0", done_cnt, to_cnt);
        end
        clear_logs();
        issue_cmd(OP_ACTCLK, 1'b0, 8'h00, RESP_LEN_ACTCLK);
        wait_tx(1);
        send_byte(8'h3C, 0);
        wait_end();
        checks++;
        if (resp_b.size() != 1 || resp_b[0] !== 8'h3C || resp_i[0] != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL post_reset_txn: resp=%0d done=%0d required 1 byte 3c done 1", resp_b.size(), done_cnt);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_version();
        test_arg_busy();
        test_histo();
        test_timeout();
        test_stray();
        test_random();
        test_reset_mid_recv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
